// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC stage and the control FSM that drives it.
//   - pc_source encodings for the next-PC mux
//   - default reset PC and exception vector
package pc_branch_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_EXC    = 2'b11
    } pcsrc_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;

endpackage

// File: rtl/pc_branch_unit_next_mux.sv
// pc_next_mux: combinational next-PC selection.
//   pc_source  : select (alu_result / target_q / jump target / exception vector)
//   pc         : current PC, upper nibble feeds the jump target
//   jump_index : instr[25:0]
//   next_pc    : selected value, unmasked
//   misaligned : selected value has nonzero bits [1:0]
module pc_next_mux
    import pc_branch_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] target_q,
    input  logic [31:0] pc,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] jump_target;

    assign jump_target = {pc[31:28], jump_index, 2'b00};

    always_comb begin
        next_pc = alu_result;
        case (pcsrc_e'(pc_source))
            PCSRC_ALU:    next_pc = alu_result;
            PCSRC_TARGET: next_pc = target_q;
            PCSRC_JUMP:   next_pc = jump_target;
            PCSRC_EXC:    next_pc = EXC_VECTOR;
            default:      next_pc = alu_result;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, branch-target register and EPC of the
// multi-cycle datapath.
//   clk, reset            : clock, async active-high reset
//   pc_write/_cond        : unconditional / branch PC write enables
//   branch_ne, zero       : branch sense and ALU zero flag
//   pc_source             : next-PC select
//   alu_result            : ALU output (normally PC+4)
//   offset_shifted        : sign-extended immediate << 2
//   jump_index            : instr[25:0]
//   target_write          : capture pc + offset_shifted into target
//   epc_write             : capture pc - 4 into epc
//   pc, target, epc       : registered state
//   pc_updated            : previous cycle's take
//   align_fault           : previous taken load had nonzero bits [1:0]
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] offset_shifted,
    input  logic [25:0] jump_index,
    input  logic        target_write,
    input  logic        epc_write,
    output logic [31:0] pc,
    output logic [31:0] target,
    output logic [31:0] epc,
    output logic        pc_updated,
    output logic        align_fault
);

    logic [31:0] next_pc;
    logic        misaligned;
    logic        take;

    pc_next_mux #(.EXC_VECTOR(EXC_VECTOR)) u_mux (
        .pc_source  (pc_source),
        .alu_result (alu_result),
        .target_q   (target),
        .pc         (pc),
        .jump_index (jump_index),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // pc_write dominates; the branch term only matters when it is low,
    // which the OR already expresses.
    assign take = pc_write | (pc_write_cond & (zero ^ branch_ne));

    // All registers read only pre-edge state, so simultaneous enables
    // (e.g. target_write with pc_source = TARGET) see the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            target      <= '0;
            epc         <= '0;
            pc_updated  <= 1'b0;
            align_fault <= 1'b0;
        end else begin
            if (take)
                pc <= next_pc & ~32'h3;
            if (target_write)
                target <= pc + offset_shifted;
            if (epc_write)
                epc <= pc - 32'd4;
            pc_updated  <= take;
            align_fault <= take & misaligned;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b0, pc_write_cond = 1'b0, branch_ne = 1'b0, zero = 1'b0;
    logic [1:0]  pc_source = 2'b00;
    logic [31:0] alu_result = '0, offset_shifted = '0;
    logic [25:0] jump_index = '0;
    logic        target_write = 1'b0, epc_write = 1'b0;
    logic [31:0] pc, target, epc;
    logic        pc_updated, align_fault;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    pc_branch_unit dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .zero(zero), .pc_source(pc_source),
        .alu_result(alu_result), .offset_shifted(offset_shifted),
        .jump_index(jump_index), .target_write(target_write), .epc_write(epc_write),
        .pc(pc), .target(target), .epc(epc),
        .pc_updated(pc_updated), .align_fault(align_fault)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural state updated from the rules
    logic [31:0] m_pc, m_target, m_epc;
    logic        m_upd, m_fault;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0; m_target = 32'h0; m_epc = 32'h0; m_upd = 1'b0; m_fault = 1'b0;
        end else begin
            bit          t;
            logic [31:0] sel, old_pc;
            old_pc = m_pc;
            if (pc_write)
                t = 1'b1;
            else if (pc_write_cond)
                t = branch_ne ? !zero : zero;
            else
                t = 1'b0;
            case (pc_source)
                2'd0: sel = alu_result;
                2'd1: sel = m_target;
                2'd2: sel = {old_pc[31:28], 28'h0} + {4'h0, jump_index, 2'b00};
                default: sel = 32'h180;
            endcase
            if (target_write) m_target = old_pc + offset_shifted;
            if (epc_write)    m_epc = old_pc - 32'd4;
            if (t)            m_pc = {sel[31:2], 2'b00};
            m_upd   = t;
            m_fault = t && (sel % 4 != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc", pc, m_pc);
            check("model_target", target, m_target);
            check("model_epc", epc, m_epc);
            check("model_pc_updated", {31'h0, pc_updated}, {31'h0, m_upd});
            check("model_align_fault", {31'h0, align_fault}, {31'h0, m_fault});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; target_write = 0; epc_write = 0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        idle();
        pc_source = 2'b00; alu_result = v; pc_write = 1;
        tick();
        idle();
    endtask

    initial begin
        // Reset with pc_write held high
        #1 reset = 1'b1;
        pc_write = 1; pc_source = 2'b00; alu_result = 32'h4;
        chk_en = 1'b1;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_target", target, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_pulses", {30'h0, pc_updated, align_fault}, 32'h0);
        reset = 1'b0;
        tick();
        check("first_pc", pc, 32'h4);
        check("first_upd", {31'h0, pc_updated}, 32'h1);
        idle();

        // BEQ taken / BNE not taken
        load_pc(32'h100);
        target_write = 1; offset_shifted = 32'hFFFF_FFF0;
        tick();
        check("br_target", target, 32'hF0);
        idle();
        pc_write_cond = 1; pc_source = 2'b01; zero = 1; branch_ne = 0;
        tick();
        check("beq_pc", pc, 32'hF0);
        check("beq_upd", {31'h0, pc_updated}, 32'h1);
        branch_ne = 1;
        tick();
        check("bne_pc", pc, 32'hF0);
        check("bne_upd", {31'h0, pc_updated}, 32'h0);
        zero = 0;
        tick();
        check("bne_nz_upd", {31'h0, pc_updated}, 32'h1);
        idle();

        // Jump
        load_pc(32'h4000_0010);
        jump_index = 26'h40; pc_source = 2'b10; pc_write = 1;
        tick();
        check("jump_pc", pc, 32'h4000_0100);
        idle();

        // Exception with EPC capture, then EPC wrap
        load_pc(32'h200);
        epc_write = 1; pc_write = 1; pc_source = 2'b11;
        tick();
        check("exc_epc", epc, 32'h1FC);
        check("exc_pc", pc, 32'h180);
        load_pc(32'h0);
        epc_write = 1;
        tick();
        check("epc_wrap", epc, 32'hFFFF_FFFC);
        idle();

        // Misaligned load
        alu_result = 32'h107; pc_source = 2'b00; pc_write = 1;
        tick();
        check("mis_pc", pc, 32'h104);
        check("mis_fault", {31'h0, align_fault}, 32'h1);
        idle();
        tick();
        check("mis_fault_clear", {31'h0, align_fault}, 32'h0);

        // All three enables together, pc_source = TARGET, pc = 0x104
        target_write = 1; offset_shifted = 32'h10; epc_write = 1; pc_write = 1; pc_source = 2'b01;
        tick();
        check("all3_pc", pc, 32'hF0);
        check("all3_target", target, 32'h114);
        check("all3_epc", epc, 32'h100);
        idle();

        // Target wrap
        load_pc(32'hFFFF_FFF0);
        target_write = 1; offset_shifted = 32'h20;
        tick();
        check("target_wrap", target, 32'h10);
        idle();

        // Async reset mid-cycle
        load_pc(32'h1000);
        target_write = 1; offset_shifted = 32'h234;
        tick();
        check("pre_rst_target", target, 32'h1234);
        idle();
        #2 reset = 1'b1;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_target", target, 32'h0);
        check("async_epc", epc, 32'h0);
        check("async_pulses", {30'h0, pc_updated, align_fault}, 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        target_write = 1; offset_shifted = 32'h10;
        tick();
        check("post_rst_target", target, 32'h10);
        idle();
        tick(); tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
